// File: rtl/hazard_pkg.sv
// Shared constants, counter-width helper and register-number type for the hazard scoreboard.
// No logic of its own; no latency or backpressure.
// Counter width covers the longest programmable unavailability window.
package hazard_pkg;

  localparam int REG_COUNT_DEF  = 16;
  localparam int NUM_SRC_DEF    = 2;
  localparam int WB_DELAY_DEF   = 2;
  localparam int LOAD_DELAY_DEF = 1;

  typedef logic [$clog2(REG_COUNT_DEF)-1:0] reg_num_t;

  function automatic int cnt_w(input int wb_delay, input int load_delay);
    int mx;
    mx = (wb_delay > load_delay) ? wb_delay : load_delay;
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/hazard_pend_cell.sv
// Per-register pending down-counter: busy while a result is still in flight.
// busy is registered state; load and clear take effect on the next edge.
// hold freezes the count; clear wins over hold, load wins over decrement.
module hazard_pend_cell import hazard_pkg::*; #(
  parameter int CNT_W = cnt_w(WB_DELAY_DEF, LOAD_DELAY_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Register scoreboard raising hazard_detected when a used source is still in flight; optional stall counter under HAZARD_STATS_EN.
// hazard_detected is combinational (zero latency) from the current counters and the source inputs.
// A hazard blocks issue; freeze holds all counters, flush clears them.
module hazard_scoreboard_unit import hazard_pkg::*; #(
  parameter int REG_COUNT  = REG_COUNT_DEF,
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int WB_DELAY   = WB_DELAY_DEF,
  parameter int LOAD_DELAY = LOAD_DELAY_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  forwarding_enable,
  input  logic                                  freeze,
  input  logic                                  flush,
  input  logic                                  issue_valid,
  input  logic                                  issue_wb_en,
  input  logic                                  issue_mem_r_en,
  input  logic [$clog2(REG_COUNT)-1:0]          issue_dest,
  input  logic [NUM_SRC-1:0]                    src_valid,
  input  logic [NUM_SRC*$clog2(REG_COUNT)-1:0]  src,
  output logic                                  hazard_detected,
  output logic [31:0]                           stall_cycles
);

  localparam int REG_W = $clog2(REG_COUNT);
  localparam int CNT_W = cnt_w(WB_DELAY, LOAD_DELAY);

  logic [REG_COUNT-1:0] busy;
  logic [CNT_W-1:0]     load_val;
  logic                 accept;

  // Checks the pre-update counters, so an instruction reading its own destination sees the old value.
  always_comb begin
    hazard_detected = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && busy[src[i*REG_W +: REG_W]]) begin
        hazard_detected = 1'b1;
      end
    end
  end

  assign accept = issue_valid && issue_wb_en && !hazard_detected && !freeze && !flush;

  always_comb begin
    load_val = '0;
    if (!forwarding_enable) begin
      load_val = CNT_W'(WB_DELAY);
    end else if (issue_mem_r_en) begin
      load_val = CNT_W'(LOAD_DELAY);
    end
  end

  for (genvar r = 0; r < REG_COUNT; r++) begin : g_pend
    hazard_pend_cell #(.CNT_W(CNT_W)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .hold     (freeze),
      .load     (accept && (issue_dest == REG_W'(r))),
      .load_val (load_val),
      .busy     (busy[r])
    );
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (issue_valid && hazard_detected && !freeze && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with hand-computed expectations.
// A second instance with a longer write-back delay holds three registers pending at reset.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst, forwarding_enable, freeze, flush;
  logic          issue_valid, issue_wb_en, issue_mem_r_en;
  reg_num_t      issue_dest;
  logic [1:0]    src_valid;
  logic [2*RW-1:0] src;
  logic          hazard_detected, hz_long;
  logic [31:0]   stall_cycles, stall_long;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut (
    .clk(clk), .rst(rst), .forwarding_enable(forwarding_enable), .freeze(freeze), .flush(flush),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_mem_r_en(issue_mem_r_en),
    .issue_dest(issue_dest), .src_valid(src_valid), .src(src),
    .hazard_detected(hazard_detected), .stall_cycles(stall_cycles)
  );

  hazard_scoreboard_unit #(.WB_DELAY(4)) dut_long (
    .clk(clk), .rst(rst), .forwarding_enable(forwarding_enable), .freeze(freeze), .flush(flush),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_mem_r_en(issue_mem_r_en),
    .issue_dest(issue_dest), .src_valid(src_valid), .src(src),
    .hazard_detected(hz_long), .stall_cycles(stall_long)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wb_en = 1'b0; issue_mem_r_en = 1'b0; issue_dest = '0;
    src_valid = 2'b00; src = '0; freeze = 1'b0; flush = 1'b0;
  endtask

  task automatic issue_w(input int d, input logic ld);
    idle();
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_mem_r_en = ld; issue_dest = d[RW-1:0];
  endtask

  task automatic read(input int s0, input int s1, input logic [1:0] v);
    idle();
    issue_valid = 1'b1;
    src = {s1[RW-1:0], s0[RW-1:0]};
    src_valid = v;
  endtask

  // Settle the combinational output, compare, then advance one cycle.
  task automatic hz(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, hazard_detected}, {31'd0, exp});
    step();
  endtask

  task automatic two_stalls();
    forwarding_enable = 1'b0;
    issue_w(3, 1'b0); hz("st_iss", 1'b0);
    read(3, 0, 2'b01); hz("st_c0", 1'b1); hz("st_c1", 1'b1);
    idle(); step();
  endtask

  initial begin
    idle();
    forwarding_enable = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    read(0, 0, 2'b11);
    #1 check("rst_stall", stall_cycles, 32'd0);
    hz("rst_haz", 1'b0);

    // Non-forwarded ALU result: two stall cycles.
    issue_w(3, 1'b0); hz("s1_iss", 1'b0);
    read(3, 3, 2'b01); hz("s1_c0", 1'b1); hz("s1_c1", 1'b1); hz("s1_c2", 1'b0);

    // Forwarded load: one stall on src[1]; forwarded ALU: none.
    forwarding_enable = 1'b1;
    issue_w(5, 1'b1); hz("s2_ld", 1'b0);
    read(0, 5, 2'b10); hz("s2_c0", 1'b1); hz("s2_c1", 1'b0);
    issue_w(6, 1'b0); hz("s2_alu", 1'b0);
    read(6, 0, 2'b01); hz("s2_r6", 1'b0);

    // Freeze holds the load counter.
    issue_w(2, 1'b1); hz("s3_ld", 1'b0);
    read(2, 0, 2'b01); freeze = 1'b1;
    hz("s3_f0", 1'b1); hz("s3_f1", 1'b1); hz("s3_f2", 1'b1);
    freeze = 1'b0;
    hz("s3_drop", 1'b1); hz("s3_clear", 1'b0);

    // Flush clears in-flight R7 and overrides a concurrent issue to R8.
    forwarding_enable = 1'b0;
    issue_w(7, 1'b0); hz("s4_iss", 1'b0);
    issue_w(8, 1'b0); flush = 1'b1; hz("s4_flush", 1'b0);
    read(7, 8, 2'b11); hz("s4_r78", 1'b0);

    // Forwarding change does not shorten an in-flight counter.
    issue_w(4, 1'b0); hz("s6_iss", 1'b0);
    forwarding_enable = 1'b1;
    read(4, 0, 2'b01); hz("s6_c0", 1'b1); hz("s6_c1", 1'b1); hz("s6_c2", 1'b0);

    // Unused source is ignored.
    forwarding_enable = 1'b0;
    issue_w(9, 1'b0); hz("s5_iss", 1'b0);
    read(0, 9, 2'b01);
    #1 check("s5_mask", {31'd0, hazard_detected}, 32'd0);
    src_valid = 2'b10; hz("s5_unmask", 1'b1);

    // Three pending in the long instance, then reset together with an issue.
    issue_w(10, 1'b0); hz("s7_i10", 1'b0);
    issue_w(11, 1'b0); hz("s7_i11", 1'b0);
    issue_w(12, 1'b0); hz("s7_i12", 1'b0);
    read(11, 12, 2'b11);
    #1 check("s7_pre_main", {31'd0, hazard_detected}, 32'd1);
    check("s7_pre_long", {31'd0, hz_long}, 32'd1);
    read(10, 0, 2'b01);
    #1 check("s7_r10_main", {31'd0, hazard_detected}, 32'd0);
    check("s7_r10_long", {31'd0, hz_long}, 32'd1);
    issue_w(13, 1'b0); rst = 1'b1;
    step();
    rst = 1'b0;
    read(10, 11, 2'b11);
    #1 check("s7_post_a_main", {31'd0, hazard_detected}, 32'd0);
    check("s7_post_a_long", {31'd0, hz_long}, 32'd0);
    read(12, 13, 2'b11);
    #1 check("s7_post_b_long", {31'd0, hz_long}, 32'd0);
    check("s7_stall_main", stall_cycles, 32'd0);
    check("s7_stall_long", stall_long, 32'd0);
    step();

    // Stall statistics: four counted stall cycles.
    two_stalls();
    two_stalls();
`ifdef HAZARD_STATS_EN
    check("stats_four", stall_cycles, 32'd4);
    force dut.stall_q = 32'hFFFF_FFFD;
    #1 release dut.stall_q;
    two_stalls();
    two_stalls();
    check("stats_sat", stall_cycles, 32'hFFFF_FFFF);
`else
    check("stats_off", stall_cycles, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 The block SHALL have parameter REG_COUNT, default 16: number of architectural registers tracked.
REQ-002 The block SHALL have parameter NUM_SRC, default 2: number of source operand ports checked per instruction.
REQ-003 The block SHALL have parameter WB_DELAY, default 2: cycles a non-forwarded result stays unavailable after issue.
REQ-004 The block SHALL have parameter LOAD_DELAY, default 1: cycles a load result stays unavailable after issue when forwarding is on.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port forwarding_enable, input, 1 bit: forwarding mode select.
REQ-008 The block SHALL have port freeze, input, 1 bit: pipeline-wide stall, such as a memory wait.
REQ-009 The block SHALL have port flush, input, 1 bit: branch-taken squash of in-flight instructions.
REQ-010 The block SHALL have port issue_valid, input, 1 bit: an instruction in ID requests issue to EXE.
REQ-011 The block SHALL have port issue_wb_en, input, 1 bit: the issuing instruction writes a register.
REQ-012 The block SHALL have port issue_mem_r_en, input, 1 bit: the issuing instruction is a load.
REQ-013 The block SHALL have port issue_dest, input, clog2(REG_COUNT) bits: the issuing instruction's destination register.
REQ-014 The block SHALL have port src_valid, input, NUM_SRC bits: per-source operand-used flags.
REQ-015 The block SHALL have port src, input, NUM_SRC x clog2(REG_COUNT) bits, packed: source register numbers.
REQ-016 The block SHALL have port hazard_detected, output, 1 bit: stall ID and insert a bubble.
REQ-017 The block SHALL have port stall_cycles, output, 32 bits: count of hazard stall cycles.

Function
REQ-018 The block SHALL keep one down-counter pend[r] per register, CNT_W = clog2(max(WB_DELAY, LOAD_DELAY) + 1) bits wide.
REQ-019 hazard_detected SHALL be combinational from the current pend[] values and the src inputs, with zero latency.
REQ-020 hazard_detected SHALL be 1 when any source i has src_valid[i]=1 and pend[src[i]] is non-zero, and 0 otherwise.
REQ-021 An accepted issue SHALL be a cycle with issue_valid=1, hazard_detected=0, freeze=0, flush=0 and issue_wb_en=1.
REQ-022 On an accepted issue, pend[issue_dest] SHALL load WB_DELAY when forwarding_enable=0.
REQ-023 On an accepted issue, pend[issue_dest] SHALL load LOAD_DELAY when forwarding_enable=1 and issue_mem_r_en=1.
REQ-024 On an accepted issue, pend[issue_dest] SHALL load 0 when forwarding_enable=1 and issue_mem_r_en=0.
REQ-025 In every cycle with freeze=0 and flush=0, each other non-zero pend SHALL decrement by 1 and zero counters SHALL stay at 0.
REQ-026 The load of pend[issue_dest] SHALL take priority over its decrement in the same cycle.
REQ-027 If issue_dest equals a source register of the same instruction, the hazard check SHALL use the pre-update counter value.
REQ-028 When freeze=1 and flush=0, all pend SHALL hold their values and no issue SHALL be recorded; hazard_detected SHALL still be evaluated.
REQ-029 When flush=1, all pend SHALL be cleared to 0 on the next edge, overriding freeze and issue.
REQ-030 A change of forwarding_enable SHALL affect only new loads; in-flight counters SHALL keep counting.
REQ-031 A blocked issue (hazard_detected=1) SHALL leave the scoreboard unchanged except for decrement.

Reset
REQ-032 When rst=1 at a clock edge, all pend SHALL become 0 and stall_cycles SHALL become 0.
REQ-033 Reset SHALL take priority over flush, freeze and issue.
REQ-034 hazard_detected SHALL read 0 in the first cycle after reset.
REQ-035 A reset asserted mid-operation SHALL abandon all pending entries.

Configuration
REQ-036 With macro HAZARD_STATS_EN defined, stall_cycles SHALL increment by 1 in each cycle with issue_valid=1, hazard_detected=1 and freeze=0.
REQ-037 With HAZARD_STATS_EN defined, stall_cycles SHALL saturate at 0xFFFFFFFF.
REQ-038 With HAZARD_STATS_EN undefined, the stall_cycles port SHALL remain present and be tied to 0, with no counter logic.

Structure
REQ-039 Shared package hazard_pkg SHALL hold the default parameter constants, the CNT_W function and the register-number typedef.
REQ-040 The per-register counter SHALL be the sub-module hazard_pend_cell, instantiated REG_COUNT times.
REQ-041 The hazard_pend_cell ports SHALL be clk, rst, clr, hold, load, load_val and busy.

Verification
REQ-042 Scenario: forwarding_enable=0, ALU op writing R3 accepted, next instruction reads R3 -> hazard_detected=1 for 2 cycles, then 0.
REQ-043 Scenario: forwarding_enable=1, load to R5 followed by an instruction reading R5 as src[1] -> exactly 1 stall cycle; a following ALU write to R6 then read of R6 -> 0 stalls.
REQ-044 Scenario: load to R2 issued, freeze=1 held 3 cycles -> hazard_detected stays 1 throughout, clears 1 cycle after freeze drops.
REQ-045 Scenario: forwarding_enable=0, issue R7 then assert flush next cycle -> pend cleared, read of R7 sees hazard_detected=0.
REQ-046 Scenario: src_valid[1]=0 with src[1]=pending register -> hazard_detected=0; rst asserted with 3 registers pending -> all clear and stall_cycles=0.
REQ-047 Scenario (HAZARD_STATS_EN defined): 4 stall cycles -> stall_cycles=4; a preloaded near-max value saturates at 0xFFFFFFFF.
